// File: rtl/kmp_prefix_builder_pkg.sv
// Shared definitions for the KMP matcher pipeline: default sizes, the
// prefix-builder state encoding and the text-end marker used by the matcher.
package kmp_pkg;

  localparam int PAT_LEN_DEF = 5;
  localparam int AW_DEF      = 3;
  localparam int DW_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } kmp_build_state_t;

  // Character value the matcher treats as end of the text stream.
  localparam logic [DW_DEF-1:0] TEXT_END = '0;

endpackage

// File: rtl/kmp_prefix_builder_if.sv
// Bundle between the prefix builder and its environment: build control,
// pattern ROM bus, LPS table read port and the builder state for observation.
interface kmp_prefix_builder_if
  import kmp_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  // start is a request sampled only while idle; busy covers the whole build;
  // done pulses for one cycle when the table is complete and valid then stays
  // high until the next accepted start. pat_data answers pat_addr one cycle later.
  logic             start;
  logic             busy;
  logic             done;
  logic             valid;
  logic [AW-1:0]    pat_addr;
  logic [DW-1:0]    pat_data;
  logic [AW-1:0]    lps_raddr;
  logic [AW-1:0]    lps_rdata;
  kmp_build_state_t state;

  modport master (
    output start, pat_data, lps_raddr,
    input  busy, done, valid, pat_addr, lps_rdata, state
  );

  modport slave (
    input  start, pat_data, lps_raddr,
    output busy, done, valid, pat_addr, lps_rdata, state
  );

endinterface

// File: rtl/kmp_prefix_builder_lps_table.sv
// PAT_LEN x AW failure-table register file: one synchronous write port and two
// combinational read ports; addresses beyond the pattern read as zero.
module kmp_lps_table #(
  parameter int PAT_LEN = 5,
  parameter int AW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [AW-1:0] fb_raddr,
  output logic [AW-1:0] fb_rdata,
  input  logic [AW-1:0] ext_raddr,
  output logic [AW-1:0] ext_rdata
);

  logic [AW-1:0] mem [PAT_LEN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < PAT_LEN; k++) mem[k] <= '0;
    end else if (we && (int'(waddr) < PAT_LEN)) begin
      mem[waddr] <= wdata;
    end
  end

  assign fb_rdata  = (int'(fb_raddr)  < PAT_LEN) ? mem[fb_raddr]  : '0;
  assign ext_rdata = (int'(ext_raddr) < PAT_LEN) ? mem[ext_raddr] : '0;

endmodule

// File: rtl/kmp_prefix_builder.sv
// Loads the search pattern from a 1-cycle-latency ROM and builds the KMP
// failure (LPS) table, one comparison step per cycle, then serves it to the matcher.
module kmp_prefix_builder
  import kmp_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input logic                clk,
  input logic                rst,
  kmp_prefix_builder_if.slave bus
);

  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] LEN_CNT = CW'(PAT_LEN);
  localparam logic [CW-1:0] LAST_I  = CW'(PAT_LEN - 1);

  kmp_build_state_t state;
  logic [CW-1:0]    ld_cnt;
  logic [CW-1:0]    i;
  logic [AW-1:0]    len;
  logic [DW-1:0]    chr [PAT_LEN];
  logic             busy, done, valid;
  logic [AW-1:0]    pat_addr;

  logic [CW-1:0] ld_next;
  logic [AW-1:0] cur_i, ld_idx, fb_raddr, fb_rdata, waddr, wdata;
  logic          we, chr_eq;

  assign ld_next  = ld_cnt + 1'b1;
  assign ld_idx   = AW'(ld_cnt - 1'b1);
  assign cur_i    = i[AW-1:0];
  assign fb_raddr = len - 1'b1;
  assign chr_eq   = (chr[cur_i] == chr[len]);

  // Table writes: lps[0] is cleared as LOAD hands over, then COMPUTE writes
  // lps[i] on every step that advances i; a fallback step writes nothing.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (state == LOAD && ld_cnt == LEN_CNT) begin
      we = 1'b1;
    end else if (state == COMPUTE) begin
      waddr = cur_i;
      if (chr_eq) begin
        we    = 1'b1;
        wdata = len + AW'(1);
      end else if (len == '0) begin
        we = 1'b1;
      end
    end
  end

  kmp_lps_table #(.PAT_LEN(PAT_LEN), .AW(AW)) u_table (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .fb_raddr  (fb_raddr),
    .fb_rdata  (fb_rdata),
    .ext_raddr (bus.lps_raddr),
    .ext_rdata (bus.lps_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ld_cnt   <= '0;
      i        <= CW'(1);
      len      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      pat_addr <= '0;
      for (int k = 0; k < PAT_LEN; k++) chr[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= LOAD;
            ld_cnt   <= '0;
            valid    <= 1'b0;
            busy     <= 1'b1;
            pat_addr <= '0;
          end
        end
        LOAD: begin
          // ROM data trails the address by one cycle, so capture lags ld_cnt.
          if (ld_cnt != '0) chr[ld_idx] <= bus.pat_data;
          ld_cnt   <= ld_next;
          pat_addr <= (ld_next < LEN_CNT) ? ld_next[AW-1:0] : AW'(PAT_LEN - 1);
          if (ld_cnt == LEN_CNT) begin
            state <= COMPUTE;
            i     <= CW'(1);
            len   <= '0;
          end
        end
        COMPUTE: begin
          if (chr_eq || len == '0) begin
            if (chr_eq) len <= len + AW'(1);
            i <= i + 1'b1;
            if (i == LAST_I) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              valid <= 1'b1;
            end
          end else begin
            len <= fb_rdata;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.valid    = valid;
  assign bus.pat_addr = pat_addr;
  assign bus.state    = state;

endmodule
